// File: rtl/zdet_pkg.sv
// Shared constants and helpers for the burst zero/ones detector.
//   ZDET_MODE_*  : detect polarity, sampled per beat
//   ZDET_GRP     : bits reduced by one NOR group
//   zdet_ngrp()  : number of NOR groups for a given data width
package zdet_pkg;
  localparam logic ZDET_MODE_ZERO = 1'b0;
  localparam logic ZDET_MODE_ONES = 1'b1;
  localparam int   ZDET_GRP       = 4;

  function automatic int zdet_ngrp(input int width);
    return width / ZDET_GRP;
  endfunction
endpackage

// File: rtl/zdet_grp.sv
// Front stage of the detector: mask/invert the beat, reduce it to one
// zero-flag per 4-bit group and tag it with its index inside the burst.
// With PIPE!=0 the group flags, valid, last and index are registered
// (stage 1); with PIPE==0 they pass straight through.
//   clk_i, rst_ni          : clock, async active-low reset
//   clr_i                  : abort; drops the current beat, restarts indexing
//   mode_i, valid_i, last_i: beat qualifiers
//   din_i, mask_i          : beat data and participation mask
//   grp_z_o                : 1 per group whose masked bits are all zero
//   valid_o, last_o, idx_o : beat presented to the accumulator stage
module zdet_grp import zdet_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int BEATS_W = 4,
  parameter int PIPE    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      mode_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  input  logic [WIDTH-1:0]          din_i,
  input  logic [WIDTH-1:0]          mask_i,
  output logic [WIDTH/ZDET_GRP-1:0] grp_z_o,
  output logic                      valid_o,
  output logic                      last_o,
  output logic [BEATS_W-1:0]        idx_o
);
  localparam int NG = zdet_ngrp(WIDTH);

  logic [WIDTH-1:0]   x;
  logic [NG-1:0]      grp_z;
  logic               acc;
  logic [BEATS_W-1:0] idx_q, idx_d;

  // Ones-detect is zero-detect on the inverted word; masked-off bits are
  // forced to 0 so they can never cause a mismatch.
  assign x   = ((mode_i == ZDET_MODE_ONES) ? ~din_i : din_i) & mask_i;
  assign acc = valid_i & ~clr_i;

  for (genvar g = 0; g < NG; g++) begin : g_nor
    assign grp_z[g] = ~|x[g*ZDET_GRP +: ZDET_GRP];
  end

  // Beat index wraps naturally modulo 2^BEATS_W.
  always_comb begin
    idx_d = idx_q;
    if (clr_i)        idx_d = '0;
    else if (valid_i) idx_d = last_i ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idx_q <= '0;
    else         idx_q <= idx_d;
  end

  if (PIPE != 0) begin : g_pipe
    logic [NG-1:0]      grp_z_q;
    logic               vld_q, last_q;
    logic [BEATS_W-1:0] idx_s_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        grp_z_q <= '0;
        vld_q   <= 1'b0;
        last_q  <= 1'b0;
        idx_s_q <= '0;
      end else begin
        vld_q <= acc;
        if (acc) begin
          grp_z_q <= grp_z;
          last_q  <= last_i;
          idx_s_q <= idx_q;
        end
      end
    end

    assign grp_z_o = grp_z_q;
    assign valid_o = vld_q;
    assign last_o  = last_q;
    assign idx_o   = idx_s_q;
  end else begin : g_comb
    assign grp_z_o = grp_z;
    assign valid_o = acc;
    assign last_o  = last_i;
    assign idx_o   = idx_q;
  end
endmodule

// File: rtl/zdet_burst.sv
// Burst zero/ones detector. Each beat is reduced to a match flag
// (all masked bits zero, or all one), accumulated over the burst, and on
// the last beat the burst summary is published with a one-cycle q_valid.
//   clk, resetl                 : clock, async active-low reset
//   clr                         : abort in-flight burst, keep held results
//   mode, din_valid, din_last   : beat qualifiers (last needs valid)
//   din, mask                   : beat data and participation mask
//   q_valid                     : result pulse
//   q_all, q_found, q_first     : all matched / some mismatch / first bad beat
//   q_ovf                       : burst longer than 2^BEATS_W beats
module zdet_burst import zdet_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int BEATS_W = 4,
  parameter int PIPE    = 1
) (
  input  logic               clk,
  input  logic               resetl,
  input  logic               clr,
  input  logic               mode,
  input  logic               din_valid,
  input  logic               din_last,
  input  logic [WIDTH-1:0]   din,
  input  logic [WIDTH-1:0]   mask,
  output logic               q_valid,
  output logic               q_all,
  output logic               q_found,
  output logic [BEATS_W-1:0] q_first,
  output logic               q_ovf
);
  localparam int NG = zdet_ngrp(WIDTH);

  logic [NG-1:0]      s_grp_z;
  logic               s_valid, s_last;
  logic [BEATS_W-1:0] s_idx;

  zdet_grp #(.WIDTH(WIDTH), .BEATS_W(BEATS_W), .PIPE(PIPE)) u_grp (
    .clk_i   (clk),
    .rst_ni  (resetl),
    .clr_i   (clr),
    .mode_i  (mode),
    .valid_i (din_valid),
    .last_i  (din_last),
    .din_i   (din),
    .mask_i  (mask),
    .grp_z_o (s_grp_z),
    .valid_o (s_valid),
    .last_o  (s_last),
    .idx_o   (s_idx)
  );

  logic               nand_g, match;
  logic               all_q, all_d, found_q, found_d, ovf_q, ovf_d;
  logic [BEATS_W-1:0] first_q, first_d, cnt_q, cnt_d;
  logic               vld_q, vld_d, r_all_q, r_all_d, r_found_q, r_found_d, r_ovf_q, r_ovf_d;
  logic [BEATS_W-1:0] r_first_q, r_first_d;
  logic               all_n, found_n;
  logic [BEATS_W-1:0] first_n;

  // NAND of the group flags is high when any group saw a set bit; the
  // final NOR turns that back into the match sense.
  assign nand_g = ~&s_grp_z;
  assign match  = ~nand_g;

  assign all_n   = all_q & match;
  assign found_n = found_q | ~match;
  assign first_n = (~match & ~found_q) ? s_idx : first_q;

  always_comb begin
    all_d     = all_q;
    found_d   = found_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    vld_d     = 1'b0;
    r_all_d   = r_all_q;
    r_found_d = r_found_q;
    r_first_d = r_first_q;
    r_ovf_d   = r_ovf_q;
    if (clr) begin
      all_d   = 1'b1;
      found_d = 1'b0;
      first_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (s_valid) begin
      if (s_last) begin
        // ovf_q already reflects a wrap by an earlier beat; the last beat's
        // own count step only matters for a burst that would continue.
        vld_d     = 1'b1;
        r_all_d   = all_n;
        r_found_d = found_n;
        r_first_d = first_n;
        r_ovf_d   = ovf_q;
        all_d     = 1'b1;
        found_d   = 1'b0;
        first_d   = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
      end else begin
        all_d   = all_n;
        found_d = found_n;
        first_d = first_n;
        cnt_d   = cnt_q + 1'b1;
        ovf_d   = ovf_q | (cnt_q == '1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      all_q     <= 1'b1;
      found_q   <= 1'b0;
      first_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
      r_all_q   <= 1'b0;
      r_found_q <= 1'b0;
      r_first_q <= '0;
      r_ovf_q   <= 1'b0;
    end else begin
      all_q     <= all_d;
      found_q   <= found_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
      r_all_q   <= r_all_d;
      r_found_q <= r_found_d;
      r_first_q <= r_first_d;
      r_ovf_q   <= r_ovf_d;
    end
  end

  assign q_valid = vld_q;
  assign q_all   = r_all_q;
  assign q_found = r_found_q;
  assign q_first = r_first_q;
  assign q_ovf   = r_ovf_q;
endmodule

// File: tb/tb_zdet_burst.sv
// Bench for zdet_burst: three instances (32b/16-beat/piped, 32b/4-beat/piped,
// 128b/8-beat/combinational) share one stimulus stream. A burst-level model
// predicts every output each cycle; a vector table and a few hand sequences
// pin down the documented corner cases with constant expectations.
module tb_zdet_burst;
  logic         clk = 1'b0;
  logic         resetl, clr, mode, dv, dl;
  logic [127:0] din, mask;

  always #5 clk = ~clk;

  logic [2:0]       qv, qa, qf, qo;
  logic [3:0]       fa;
  logic [1:0]       fb;
  logic [2:0]       fc;
  logic [2:0][3:0]  qi;

  assign qi[0] = fa;
  assign qi[1] = {2'b00, fb};
  assign qi[2] = {1'b0, fc};

  zdet_burst #(.WIDTH(32), .BEATS_W(4), .PIPE(1)) u_a (
    .clk(clk), .resetl(resetl), .clr(clr), .mode(mode), .din_valid(dv), .din_last(dl),
    .din(din[31:0]), .mask(mask[31:0]), .q_valid(qv[0]), .q_all(qa[0]), .q_found(qf[0]),
    .q_first(fa), .q_ovf(qo[0]));

  zdet_burst #(.WIDTH(32), .BEATS_W(2), .PIPE(1)) u_b (
    .clk(clk), .resetl(resetl), .clr(clr), .mode(mode), .din_valid(dv), .din_last(dl),
    .din(din[31:0]), .mask(mask[31:0]), .q_valid(qv[1]), .q_all(qa[1]), .q_found(qf[1]),
    .q_first(fb), .q_ovf(qo[1]));

  zdet_burst #(.WIDTH(128), .BEATS_W(3), .PIPE(0)) u_c (
    .clk(clk), .resetl(resetl), .clr(clr), .mode(mode), .din_valid(dv), .din_last(dl),
    .din(din), .mask(mask), .q_valid(qv[2]), .q_all(qa[2]), .q_found(qf[2]),
    .q_first(fc), .q_ovf(qo[2]));

  // ---------------- reference model (burst level) ----------------
  typedef struct {
    int due;
    bit all;
    bit found;
    int first;
    bit ovf;
  } res_t;

  int   W[3]   = '{32, 32, 128};
  int   BW[3]  = '{4, 2, 3};
  int   LAT[3] = '{2, 2, 1};
  res_t pend[3][$];
  bit   bits[3][$];
  res_t held[3];
  int   cyc, nvec, nmis;

  task automatic cmp(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit beat_match(input int k);
    logic [127:0] x, wm;
    x  = (mode ? ~din : din) & mask;
    wm = (W[k] == 128) ? '1 : ((128'd1 << W[k]) - 128'd1);
    return (x & wm) == 128'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pend[k].delete();
      bits[k].delete();
      held[k] = '{0, 0, 0, 0, 0};
    end
  endtask

  // Apply the inputs sampled at the edge that ends cycle 'cyc'.
  task automatic model_edge();
    res_t r;
    int   n;
    if (resetl) begin
      for (int k = 0; k < 3; k++) begin
        if (clr) begin
          while (pend[k].size() > 0 && pend[k][$].due > cyc) void'(pend[k].pop_back());
          bits[k].delete();
        end else if (dv) begin
          bits[k].push_back(beat_match(k));
          if (dl) begin
            n = bits[k].size();
            r = '{cyc + LAT[k], 1, 0, 0, 0};
            for (int i = 0; i < n; i++) begin
              if (!bits[k][i]) begin
                if (!r.found) r.first = i % (1 << BW[k]);
                r.found = 1;
                r.all   = 0;
              end
            end
            r.ovf = (n > (1 << BW[k]));
            pend[k].push_back(r);
            bits[k].delete();
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    bit ev;
    for (int k = 0; k < 3; k++) begin
      ev = (pend[k].size() > 0) && (pend[k][0].due == cyc);
      if (ev) held[k] = pend[k].pop_front();
      cmp($sformatf("dut%0d q_valid", k), int'(qv[k]), int'(ev));
      cmp($sformatf("dut%0d q_all", k),   int'(qa[k]), int'(held[k].all));
      cmp($sformatf("dut%0d q_found", k), int'(qf[k]), int'(held[k].found));
      cmp($sformatf("dut%0d q_first", k), int'(qi[k]), held[k].first);
      cmp($sformatf("dut%0d q_ovf", k),   int'(qo[k]), int'(held[k].ovf));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit l, input bit c, input bit md,
                       input logic [127:0] d, input logic [127:0] m);
    dv = v; dl = l; clr = c; mode = md; din = d; mask = m;
    step();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, '0);
  endtask

  // ---------------- directed vectors for instance A ----------------
  typedef struct {
    bit          c, md, v, l;
    logic [31:0] d, m;
    bit          ev, ea, ef;
    int          ei;
    bit          eo;
  } row_t;

  row_t tbl[22];
  logic [127:0] r;

  initial begin
    nvec = 0; nmis = 0; cyc = 0;
    resetl = 1'b0; clr = 0; mode = 0; dv = 0; dl = 0; din = '0; mask = '0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("reset dut%0d q_valid", k), int'(qv[k]), 0);
      cmp($sformatf("reset dut%0d q_all", k), int'(qa[k]), 0);
    end
    step();
    step();
    resetl = 1'b1;

    //        c  md v  l  din           mask          ev ea ef ei eo
    tbl[0]  = '{0, 0, 1, 1, 32'h0,        32'hFFFFFFFF, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 32'h0,        32'hFFFFFFFF, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 32'h0,        32'hFFFFFFFF, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 32'h00010000, 32'hFFFFFFFF, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 32'h0,        32'hFFFFFFFF, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 0, 32'h0,        32'hFFFFFFFF, 1, 0, 1, 2, 0};
    tbl[7]  = '{0, 0, 1, 1, 32'h0,        32'hFFFFFFFF, 0, 0, 1, 2, 0};
    tbl[8]  = '{0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 1, 32'h1234FFFF, 32'h0000FFFF, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 1, 32'h1234FFFF, 32'h0001FFFF, 1, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 1, 1, 32'h0,        32'hFFFFFFFF, 0, 0, 1, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 0};
    tbl[15] = '{1, 0, 1, 1, 32'h1,        32'hFFFFFFFF, 0, 0, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 0};
    tbl[18] = '{0, 0, 1, 1, 32'hFFFFFFFF, 32'h0,        0, 0, 1, 0, 0};
    tbl[19] = '{0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0};
    tbl[20] = '{0, 0, 0, 1, 32'h1,        32'hFFFFFFFF, 0, 1, 0, 0, 0};
    tbl[21] = '{0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 0};

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].c, tbl[i].md, {96'h0, tbl[i].d}, {96'h0, tbl[i].m});
      cmp($sformatf("tbl%0d q_valid", i), int'(qv[0]), int'(tbl[i].ev));
      cmp($sformatf("tbl%0d q_all", i),   int'(qa[0]), int'(tbl[i].ea));
      cmp($sformatf("tbl%0d q_found", i), int'(qf[0]), int'(tbl[i].ef));
      cmp($sformatf("tbl%0d q_first", i), int'(qi[0]), tbl[i].ei);
      cmp($sformatf("tbl%0d q_ovf", i),   int'(qo[0]), int'(tbl[i].eo));
    end

    // 6-beat zero burst on the 4-beat instance overflows.
    for (int i = 0; i < 6; i++) drive(1, i == 5, 0, 0, '0, '1);
    idle();
    cmp("ovf6 q_valid", int'(qv[1]), 1);
    cmp("ovf6 q_all",   int'(qa[1]), 1);
    cmp("ovf6 q_ovf",   int'(qo[1]), 1);
    cmp("ovf6 q_first", int'(qi[1]), 0);

    // Mismatch on beat 5 of 6: index wraps to 1.
    for (int i = 0; i < 6; i++) drive(1, i == 5, 0, 0, (i == 5) ? 128'd1 : 128'd0, '1);
    idle();
    cmp("ovf6b q_valid", int'(qv[1]), 1);
    cmp("ovf6b q_found", int'(qf[1]), 1);
    cmp("ovf6b q_first", int'(qi[1]), 1);
    cmp("ovf6b q_ovf",   int'(qo[1]), 1);

    // Wide combinational instance: single 1 at bit 127, latency 1.
    r = '0; r[127] = 1'b1;
    drive(1, 1, 0, 0, r, '1);
    cmp("w128 q_valid", int'(qv[2]), 1);
    cmp("w128 q_all",   int'(qa[2]), 0);
    cmp("w128 q_first", int'(qi[2]), 0);
    cmp("w128 piped not yet", int'(qv[0]), 0);
    idle();
    cmp("w128 piped pulse", int'(qv[0]), 1);

    // Reset mid-burst: outputs drop immediately, next burst is clean.
    drive(1, 0, 0, 0, 128'd1, '1);
    drive(1, 0, 0, 0, '0, '1);
    dv = 0;
    #2 resetl = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("rst dut%0d q_all", k), int'(qa[k]), 0);
      cmp($sformatf("rst dut%0d q_first", k), int'(qi[k]), 0);
      cmp($sformatf("rst dut%0d q_found", k), int'(qf[k]), 0);
    end
    step();
    resetl = 1'b1;
    drive(1, 1, 0, 0, '0, '1);
    idle();
    cmp("post-rst q_valid", int'(qv[0]), 1);
    cmp("post-rst q_all",   int'(qa[0]), 1);
    cmp("post-rst q_first", int'(qi[0]), 0);

    // Randomized traffic checked against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [127:0] d, m;
      bit md;
      md = $urandom_range(1, 0);
      case ($urandom_range(3, 0))
        0: m = '1;
        1: m = '0;
        2: m = {$urandom, $urandom, $urandom, $urandom};
        default: m = {96'h0, 32'hFFFF << $urandom_range(16, 0)};
      endcase
      d = md ? '1 : '0;
      case ($urandom_range(5, 0))
        0: d = {$urandom, $urandom, $urandom, $urandom};
        1: d[$urandom_range(127, 0)] = ~d[0];
        default: ;
      endcase
      drive($urandom_range(9, 0) < 7,
            (i < 1500) ? ($urandom_range(3, 0) == 0) : ($urandom_range(23, 0) == 0),
            $urandom_range(49, 0) == 0, md, d, m);
    end
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/zdet_burst.md
Name: zdet_burst

Overview:
- Parametrised, pipelined successor of the fixed 32-bit NOR zero detector.
- Reduces a WIDTH-bit word per beat to a match flag: all masked bits zero, or all masked bits one.
- Accumulates the flag across a multi-beat burst and reports all-match, first-mismatch beat index and overflow.
- Sits beside blitter/GPU datapaths that need zero or ones tests over long operands streamed one word per clock.

Parameters:
- WIDTH, 32, data width per beat; multiple of 4, range 4..128.
- BEATS_W, 4, width of beat index; a burst holds up to 2^BEATS_W beats.
- PIPE, 1, 1 = registered group-reduction stage (latency 2); 0 = purely combinational reduction (latency 1).

Ports:
- clk  in  1  system clock
- resetl  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort: flush pipeline and accumulators
- mode  in  1  0 = zero detect, 1 = ones detect; sampled with each beat
- din_valid  in  1  beat present this cycle
- din_last  in  1  final beat of burst; qualified by din_valid
- din  in  WIDTH  data beat
- mask  in  WIDTH  1 = bit participates; sampled with each beat
- q_valid  out  1  one-cycle pulse: result fields updated
- q_all  out  1  every beat of the burst matched
- q_found  out  1  at least one beat mismatched
- q_first  out  BEATS_W  index of the first mismatching beat; 0 if none
- q_ovf  out  1  burst exceeded 2^BEATS_W beats

Behaviour:
- Reset (resetl low, asynchronous): all outputs 0, beat counter 0, accumulators cleared, pipeline valid 0.
- Per-beat match:
  - x = (mode ? ~din : din) & mask.
  - match = ~|x, formed as NOR4 groups then NAND of groups then final NOR, as in the 32-bit cell.
  - mask == 0 gives match = 1.
- PIPE=1: stage 1 registers the WIDTH/4 group flags plus valid, last and the beat index. Stage 2 accumulates.
- Latency:
  - last beat accepted in cycle t → q_valid high in cycle t+2 (PIPE=1) or t+1 (PIPE=0).
  - No input stall; din_valid may be high every cycle.
- Accumulator state: acc_all, found, first_idx, beat_cnt, ovf. On each valid beat reaching stage 2:
  - acc_all &= match.
  - If !match && !found: found ← 1, first_idx ← beat index.
  - beat_cnt increments. On wrap from 2^BEATS_W-1, ovf ← 1 (sticky for the burst); beat_cnt wraps, and the index of a later first mismatch is taken modulo 2^BEATS_W.
- Last beat at stage 2:
  - Copy the final values (including this beat) to the q_* fields and pulse q_valid.
  - Accumulators return to the idle values acc_all=1, found=0, first_idx=0, cnt=0, ovf=0 in the same cycle.
- Back-to-back bursts: the first beat of burst B may follow the last beat of A with no bubble. It accumulates into fresh state and the two bursts never mix.
- Single-beat burst (din_valid & din_last on first beat) is legal; q_first=0.
- q_all, q_found, q_first, q_ovf hold their value between pulses. q_valid is high for exactly one cycle per burst.
- clr:
  - Clears stage-1 valid and all accumulators, and forces q_valid to 0 next cycle.
  - Held q_* result fields are kept.
  - A beat presented with clr in the same cycle is dropped.
  - A last beat in flight in stage 1 when clr asserts produces no result.
- din_last without din_valid is ignored.
- resetl asserted mid-burst: everything returns to reset values immediately, and no result is produced.

Decomposition:
- Shared package zdet_pkg holds:
  - constants ZDET_MODE_ZERO=1'b0 and ZDET_MODE_ONES=1'b1
  - ZDET_GRP=4 (bits per NOR group)
  - function to compute the group count from WIDTH
- One sub-module: zdet_grp (mask/invert, NOR4 groups, optional register stage), parameterised by WIDTH and PIPE. zdet_burst instantiates it and holds the accumulator and output registers.

Test Plan:
- WIDTH=32, PIPE=1, mode=0, mask=FFFFFFFF, single beat din=00000000 with last → q_valid at t+2, q_all=1, q_found=0, q_first=0, q_ovf=0.
- 4-beat burst, mode=0, din = 0, 0, 00010000, 0 → q_all=0, q_found=1, q_first=2. A second 2-beat burst of zeros follows immediately → q_all=1, q_found=0 on the next pulse, with exactly 2 q_valid pulses total.
- mode=1, mask=0000FFFF, din=1234FFFF single beat → q_all=1. Same beat with mask=0001FFFF → q_all=0.
- BEATS_W=2, 6-beat zero burst → q_ovf=1, q_all=1. Mismatch on beat 5 of a 6-beat burst → q_first=1, q_ovf=1.
- clr asserted the cycle after a last beat (PIPE=1) → no q_valid, previous q_all/q_first held. resetl pulsed low mid-burst → outputs 0 asynchronously, next burst starts clean.
- PIPE=0, WIDTH=128, one beat with a single 1 at bit 127 → q_valid at t+1, q_all=0, q_first=0.
